// File: rtl/vco_adc_spi_pkg.sv
// Shared opcodes and FSM state encoding for the VCO-ADC SPI responder.
package vco_adc_spi_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_STAT = 8'h05;
    localparam logic [7:0] CMD_CLR  = 8'h06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vco_adc_sample_fifo.sv
// First-word-fall-through sample FIFO; a pop on an empty FIFO is ignored,
// and a push while full is accepted only when a pop frees a slot in the same cycle.
module vco_adc_sample_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vco_adc_spi_responder.sv
// SPI mode-0 responder streaming buffered VCO-ADC samples; SPI pins are
// oversampled on the system clock.
//   state | meaning
//   IDLE  | CSB high, waiting for CSB fall
//   CMD   | shifting in the command byte
//   DATA  | shifting tx_sr out on SDO
//   DONE  | transfer complete, waiting for CSB high
module vco_adc_spi_responder
    import vco_adc_spi_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          spi_csb,
    input  logic          spi_sck,
    input  logic          spi_sdi,
    output logic          spi_sdo,
    output logic          spi_sdo_oe,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic          underflow,
    output logic          busy
);

    localparam int BW = $clog2(DW);

    logic          csb_meta_q, csb_sync_q, csb_prev_q;
    logic          sck_meta_q, sck_sync_q, sck_prev_q;
    logic          sdi_meta_q, sdi_sync_q;
    logic          sck_rise, sck_fall, csb_fall;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]    cmd_sr_q, cmd_sr_d;
    logic [DW-1:0] tx_sr_q, tx_sr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          sdo_q, sdo_d;
    logic          sdo_oe_q, sdo_oe_d;
    logic          busy_q, busy_d;
    logic [7:0]    cmd_byte;

    logic          fifo_pop;
    logic [DW-1:0] fifo_dout;
    logic          fifo_full, fifo_empty;

    vco_adc_sample_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clock  (clock),
        .resetb (resetb),
        .push   (sample_valid),
        .pop    (fifo_pop),
        .din    (sample_data),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign sck_rise = sck_sync_q && !sck_prev_q && !csb_sync_q;
    assign sck_fall = !sck_sync_q && sck_prev_q && !csb_sync_q;
    assign csb_fall = csb_prev_q && !csb_sync_q;
    assign cmd_byte = {cmd_sr_q, sdi_sync_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        tx_sr_d     = tx_sr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = BW'(7);
                end
            end
            CMD: begin
                if (sck_rise) begin
                    cmd_sr_d  = cmd_byte[6:0];
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d = BW'(DW - 1);
                        case (cmd_byte)
                            CMD_READ: begin
                                fifo_pop = 1'b1;
                                tx_sr_d  = fifo_empty ? '0 : fifo_dout;
                                state_d  = DATA;
                            end
                            CMD_STAT: begin
                                tx_sr_d = {overflow_q, underflow_q, 3'b000, fifo_count,
                                           {(DW - 5 - CW){1'b0}}};
                                state_d = DATA;
                            end
                            CMD_CLR: begin
                                overflow_d  = 1'b0;
                                underflow_d = 1'b0;
                                state_d     = DONE;
                            end
                            default: state_d = DONE;
                        endcase
                    end
                end
            end
            DATA: begin
                // The fall right after the command byte must keep the MSB on SDO.
                if (sck_rise) begin
                    if (bit_cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else if (sck_fall && bit_cnt_q != BW'(DW - 1)) begin
                    tx_sr_d = tx_sr_q << 1;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (csb_sync_q) begin
            state_d = IDLE;
        end
        // New events are applied after CLR so that a same-cycle set wins.
        if (fifo_pop && fifo_empty) begin
            underflow_d = 1'b1;
        end
        if (sample_valid && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
        sdo_oe_d = (state_d == DATA);
        sdo_d    = sdo_oe_d && tx_sr_d[DW-1];
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            csb_meta_q  <= 1'b1;
            csb_sync_q  <= 1'b1;
            csb_prev_q  <= 1'b1;
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            tx_sr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            csb_meta_q  <= spi_csb;
            csb_sync_q  <= csb_meta_q;
            csb_prev_q  <= csb_sync_q;
            sck_meta_q  <= spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            sdi_meta_q  <= spi_sdi;
            sdi_sync_q  <= sdi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            tx_sr_q     <= tx_sr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = sdo_oe_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vco_adc_spi_responder.sv
// Scoreboard bench for the VCO-ADC SPI responder: a host model drives SPI
// transfers and a queue-based reference predicts FIFO contents and flags.
module tb_vco_adc_spi_responder;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_STAT = 8'h05;
    localparam logic [7:0] OP_CLR  = 8'h06;

    logic          clock = 1'b0;
    logic          resetb;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          spi_csb, spi_sck, spi_sdi;
    logic          spi_sdo, spi_sdo_oe;
    logic [CW-1:0] fifo_count;
    logic          overflow, underflow, busy;

    vco_adc_spi_responder #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock        (clock),
        .resetb       (resetb),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .spi_csb      (spi_csb),
        .spi_sck      (spi_sck),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .spi_sdo_oe   (spi_sdo_oe),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow),
        .busy         (busy)
    );

    // 20-unit clock period (50 MHz); one SCK period is ten clocks (5 MHz).
    always #10 clock = ~clock;

    // Reference model: plain queue of stored samples and two sticky flags.
    logic [DW-1:0] m_fifo[$];
    bit            m_ovf, m_udf;

    function automatic void m_push(logic [DW-1:0] d);
        if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [DW-1:0] m_read();
        if (m_fifo.size() == 0) begin
            m_udf = 1'b1;
            return '0;
        end
        return m_fifo.pop_front();
    endfunction

    function automatic logic [31:0] m_stat();
        return (m_ovf ? 32'h8000 : 32'h0) + (m_udf ? 32'h4000 : 32'h0)
               + 32'(m_fifo.size()) * 32'd256;
    endfunction

    // Scoreboard: expectations are queued at stimulus time, observations by the host side.
    string       exp_name_q[$];
    logic [31:0] exp_val_q[$];
    logic [31:0] act_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic sb_expect(input string name, input logic [31:0] e);
        exp_name_q.push_back(name);
        exp_val_q.push_back(e);
    endtask

    task automatic sb_observe(input logic [31:0] a);
        act_q.push_back(a);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            while (act_q.size() > 0) begin
                logic [31:0] a;
                a = act_q.pop_front();
                n_checks++;
                if (exp_val_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_observation: got %0h, nothing expected", a);
                end else begin
                    string       nm;
                    logic [31:0] e;
                    nm = exp_name_q.pop_front();
                    e  = exp_val_q.pop_front();
                    if (a !== e) begin
                        n_errors++;
                        $display("FAIL %s: got %0h expected %0h", nm, a, e);
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_sample(input logic [DW-1:0] d);
        @(negedge clock);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clock);
        sample_valid = 1'b0;
        m_push(d);
    endtask

    // One SCK period; optionally strobes sample_valid into the cycle the rise is decoded.
    task automatic spi_bit(input logic mosi, input bit inj, input logic [DW-1:0] inj_d,
                           output logic miso);
        spi_sdi = mosi;
        repeat (5) @(negedge clock);
        miso    = spi_sdo;
        spi_sck = 1'b1;
        if (inj) begin
            @(posedge clock);
            @(posedge clock);
            @(negedge clock);
            sample_valid = 1'b1;
            sample_data  = inj_d;
            @(negedge clock);
            sample_valid = 1'b0;
            repeat (2) @(negedge clock);
        end else begin
            repeat (5) @(negedge clock);
        end
        spi_sck = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input int ndata, input bit inj,
                            input logic [DW-1:0] inj_d, output logic [DW-1:0] rx,
                            output logic oe_seen);
        logic b;
        @(negedge clock);
        spi_csb = 1'b0;
        spi_sck = 1'b0;
        repeat (5) @(negedge clock);
        for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], inj && (i == 7), inj_d, b);
        rx      = '0;
        oe_seen = 1'b0;
        for (int i = 0; i < ndata; i++) begin
            if (i == 0) oe_seen = spi_sdo_oe;
            spi_bit(1'b0, 1'b0, '0, b);
            rx = {rx[DW-2:0], b};
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic end_xfer();
        spi_csb = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic do_read(input bit inj, input logic [DW-1:0] inj_d, input string nm);
        logic [DW-1:0] rx;
        logic          oe;
        sb_expect(nm, 32'(m_read()));
        if (inj) m_push(inj_d);
        sb_expect({nm, "_oe"}, 32'd1);
        spi_xfer(OP_READ, DW, inj, inj_d, rx, oe);
        sb_observe(32'(rx));
        sb_observe(32'(oe));
        end_xfer();
    endtask

    task automatic do_stat(input string nm);
        logic [DW-1:0] rx;
        logic          oe;
        sb_expect(nm, m_stat());
        spi_xfer(OP_STAT, DW, 1'b0, '0, rx, oe);
        sb_observe(32'(rx));
        end_xfer();
    endtask

    task automatic do_clr();
        logic [DW-1:0] rx;
        logic          oe;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        spi_xfer(OP_CLR, 0, 1'b0, '0, rx, oe);
        end_xfer();
    endtask

    task automatic check_regs(input string tag);
        sb_expect({tag, "_count"}, 32'(m_fifo.size()));
        sb_observe(32'(fifo_count));
        sb_expect({tag, "_overflow"}, 32'(m_ovf));
        sb_observe(32'(overflow));
        sb_expect({tag, "_underflow"}, 32'(m_udf));
        sb_observe(32'(underflow));
        sb_expect({tag, "_busy"}, 32'd0);
        sb_observe(32'(busy));
        sb_expect({tag, "_sdo_oe"}, 32'd0);
        sb_observe(32'(spi_sdo_oe));
    endtask

    initial begin
        logic [DW-1:0] rx;
        logic          oe;
        resetb       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        spi_csb      = 1'b1;
        spi_sck      = 1'b0;
        spi_sdi      = 1'b0;
        m_ovf        = 1'b0;
        m_udf        = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            spi_csb = 1'($urandom_range(0, 1));
            spi_sck = 1'($urandom_range(0, 1));
            spi_sdi = 1'($urandom_range(0, 1));
        end
        sb_expect("rst_sdo", 32'd0);
        sb_observe(32'(spi_sdo));
        check_regs("rst");
        spi_csb = 1'b1;
        spi_sck = 1'b0;
        spi_sdi = 1'b0;
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        repeat (4) @(negedge clock);

        // Basic read
        push_sample(16'hAB40);
        check_regs("s2_pre");
        do_read(1'b0, '0, "s2_read");
        check_regs("s2_post");

        // Overflow, then drain
        for (int i = 1; i <= 5; i++) push_sample(16'(i));
        check_regs("s3_full");
        for (int i = 0; i < 4; i++) do_read(1'b0, '0, "s3_read");
        check_regs("s3_drained");

        // Status and clear
        do_stat("s4_stat_ovf");
        do_clr();
        check_regs("s4_clr");
        do_stat("s4_stat_clean");

        // Underflow, then aborted read
        do_read(1'b0, '0, "s5_empty_read");
        check_regs("s5_udf");
        push_sample(16'h1111);
        push_sample(16'h2222);
        void'(m_read());
        spi_xfer(OP_READ, 4, 1'b0, '0, rx, oe);
        sb_expect("s5_busy_mid", 32'd1);
        sb_observe(32'(busy));
        spi_csb = 1'b1;
        repeat (3) @(negedge clock);
        sb_expect("s5_busy_abort", 32'd0);
        sb_observe(32'(busy));
        repeat (3) @(negedge clock);
        check_regs("s5_abort");
        do_read(1'b0, '0, "s5_next_read");

        // Push coincident with READ decode
        push_sample(16'h5A5A);
        do_read(1'b1, 16'hC3C3, "s6_coincident");
        check_regs("s6_post");
        do_read(1'b0, '0, "s6_stored");

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    int n;
                    n = int'($urandom_range(1, 3));
                    for (int k = 0; k < n; k++) push_sample(16'($urandom));
                end
                2: do_read(1'($urandom_range(0, 1)), 16'($urandom), "rnd_read");
                3: do_stat("rnd_stat");
                default: do_clr();
            endcase
            check_regs("rnd");
        end

        repeat (5) @(negedge clock);
        if (exp_val_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_expectations: got %0d unmatched expected 0", exp_val_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
